// File: rtl/am_pkg.sv
// Shared constants and helpers for the AM/FM receive blocks.
// Samples are 8-bit offset binary with MID as the zero level.
package am_pkg;

    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] MID = 8'd128;
    localparam logic [DATA_W-1:0] ENV_MAX = 8'd255;

    // Rectified magnitude about MID: 0 -> 128, 255 -> 127.
    function automatic logic [DATA_W-1:0] abs_offset(input logic [DATA_W-1:0] din);
        return (din >= MID) ? (din - MID) : (MID - din);
    endfunction

endpackage

// File: rtl/am_peak_window.sv
// Peak-hold over fixed windows of WIN_LEN valid magnitudes; flags the closing sample
// and presents the completed window peak alongside it.
module am_peak_window
    import am_pkg::*;
#(
    parameter int unsigned WIN_LEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] mag_i,
    input  logic              mag_valid_i,
    output logic [DATA_W-1:0] peak_o,
    output logic              done_o,
    output logic              busy_o
);

    localparam int unsigned CntW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(WIN_LEN - 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [DATA_W-1:0] cur;
    logic              last;

    assign cur  = (mag_i > peak_q) ? mag_i : peak_q;
    assign last = (cnt_q == LastIdx);

    always_comb begin
        cnt_d  = cnt_q;
        peak_d = peak_q;
        if (mag_valid_i) begin
            if (last) begin
                cnt_d  = '0;
                peak_d = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                peak_d = cur;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            peak_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            peak_q <= peak_d;
        end
    end

    // The closing sample's own magnitude must count toward its window's peak.
    assign peak_o = cur;
    assign done_o = mag_valid_i && last;
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/am_demod.sv
// Envelope AM demodulator: rectify, peak-hold per window, boxcar-average the last
// 2^AVG_LOG2 window peaks and emit one envelope sample per completed window.
module am_demod
    import am_pkg::*;
#(
    parameter int unsigned WIN_LEN  = 32,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic [DATA_W-1:0] env,
    output logic              env_valid,
    output logic              win_busy
);

    localparam int unsigned Depth = 1 << AVG_LOG2;
    localparam int unsigned SumW  = DATA_W + AVG_LOG2;
    localparam int unsigned FillW = AVG_LOG2 + 1;

    logic [DATA_W-1:0] mag_q;
    logic              mag_v_q;
    logic [DATA_W-1:0] win_peak;
    logic              win_done;
    logic [DATA_W-1:0] hist_q [Depth];
    logic [FillW-1:0]  fill_q;
    logic              hist_v_q;
    logic [SumW-1:0]   sum;
    logic [DATA_W-1:0] avg;
    logic [DATA_W:0]   scaled;
    logic [DATA_W-1:0] env_d;
    logic              strobe_d;
    logic [DATA_W-1:0] env_q;
    logic              env_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q   <= '0;
            mag_v_q <= 1'b0;
        end else begin
            mag_v_q <= din_valid;
            if (din_valid) begin
                mag_q <= abs_offset(din);
            end
        end
    end

    am_peak_window #(
        .WIN_LEN (WIN_LEN)
    ) u_peak_window (
        .clk_i       (clk),
        .rst_i       (rst),
        .mag_i       (mag_q),
        .mag_valid_i (mag_v_q),
        .peak_o      (win_peak),
        .done_o      (win_done),
        .busy_o      (win_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                hist_q[i] <= '0;
            end
            fill_q   <= '0;
            hist_v_q <= 1'b0;
        end else begin
            hist_v_q <= win_done;
            if (win_done) begin
                for (int unsigned i = Depth - 1; i > 0; i--) begin
                    hist_q[i] <= hist_q[i-1];
                end
                hist_q[0] <= win_peak;
                if (fill_q != FillW'(Depth)) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
        end
    end

    // Peaks top out at 128, so the doubled average can reach 256 and must clip.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            sum = sum + SumW'(hist_q[i]);
        end
        avg      = DATA_W'(sum >> AVG_LOG2);
        scaled   = {avg, 1'b0};
        env_d    = scaled[DATA_W] ? ENV_MAX : scaled[DATA_W-1:0];
        strobe_d = hist_v_q && (fill_q == FillW'(Depth));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            env_q       <= '0;
            env_valid_q <= 1'b0;
        end else begin
            env_valid_q <= strobe_d;
            if (strobe_d) begin
                env_q <= env_d;
            end
        end
    end

    assign env       = env_q;
    assign env_valid = env_valid_q;

endmodule

// File: tb/tb_am_demod.sv
// Directed bench for am_demod (WIN_LEN=32, AVG_LOG2=2) with hand-derived strobe
// timing and envelope values.
module tb_am_demod;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] env;
    logic       env_valid;
    logic       win_busy;

    am_demod #(
        .WIN_LEN  (32),
        .AVG_LOG2 (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .env       (env),
        .env_valid (env_valid),
        .win_busy  (win_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tick_no, strobes, first_tick, last_tick, spacing, min_env, max_env;
    int env_seq [16];
    int phase;
    logic [7:0] last_env;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        tick_no = 0; strobes = 0; first_tick = -1; last_tick = -1; spacing = -1;
        min_env = 999; max_env = -1; last_env = 8'd0;
        for (int i = 0; i < 16; i++) env_seq[i] = -1;
    endtask

    // One clock: drive inputs, take the edge, observe 1 time unit later.
    task automatic tick(input logic [7:0] d, input logic v);
        din = d;
        din_valid = v;
        @(posedge clk);
        #1;
        tick_no++;
        if (env_valid === 1'b1) begin
            strobes++;
            if (strobes == 1) first_tick = tick_no;
            else spacing = tick_no - last_tick;
            last_tick = tick_no;
            last_env = env;
            if (int'(env) < min_env) min_env = int'(env);
            if (int'(env) > max_env) max_env = int'(env);
            if (strobes <= 16) env_seq[strobes-1] = int'(env);
        end
    endtask

    // Reset edge with din_valid high, so any sample leak past reset shows up later.
    task automatic reset_pulse();
        rst = 1'b1;
        tick(8'd0, 1'b1);
        rst = 1'b0;
        chk("rst_env", {24'd0, env}, 32'd0);
        chk("rst_env_valid", {31'd0, env_valid}, 32'd0);
        chk("rst_win_busy", {31'd0, win_busy}, 32'd0);
    endtask

    function automatic logic [7:0] alt(input int j, input int amp);
        return (j % 2 == 1) ? 8'(128 + amp) : 8'(128 - amp);
    endfunction

    initial begin
        rst = 1'b1; din = 8'd0; din_valid = 1'b0;
        tick(8'd0, 1'b0);
        reset_pulse();

        // Zero carrier: windows end at samples 128/160/192 -> strobes at ticks 130/162/194.
        clear_stats();
        for (int j = 1; j <= 200; j++) tick(8'd128, 1'b1);
        repeat (2) tick(8'd0, 1'b0);
        chk("zero_first_tick", first_tick, 130);
        chk("zero_strobes", strobes, 3);
        chk("zero_max_env", max_env, 0);
        chk("zero_spacing", spacing, 32);

        // Full-scale alternation: peak 128, doubled average 256 clips to 255.
        reset_pulse();
        clear_stats();
        for (int j = 1; j <= 192; j++) tick((j % 2 == 1) ? 8'd0 : 8'd255, 1'b1);
        repeat (2) tick(8'd0, 1'b0);
        chk("fs_strobes", strobes, 3);
        chk("fs_env", {24'd0, last_env}, 32'd255);
        chk("fs_min_env", min_env, 255);
        chk("fs_spacing", spacing, 32);

        // DDS carrier, amplitude 64: sampled peaks 63..64 -> env 126..128.
        reset_pulse();
        clear_stats();
        phase = 0;
        for (int j = 1; j <= 256; j++) begin
            tick(8'(128 + int'(64.0 * $sin(2.0 * 3.14159265358979 * phase / 32768.0))), 1'b1);
            phase = (phase + 1920) % 32768;
        end
        repeat (2) tick(8'd0, 1'b0);
        chk("dds_strobes", strobes, 5);
        chk("dds_first_tick", first_tick, 130);
        chk("dds_min_ok", {31'd0, min_env >= 126}, 32'd1);
        chk("dds_max_ok", {31'd0, max_env <= 130}, 32'd1);

        // Amplitude step 32 -> 96 after sample 128: boxcar ramp 64,96,128,160,192.
        reset_pulse();
        clear_stats();
        for (int j = 1; j <= 256; j++) tick(alt(j, (j <= 128) ? 32 : 96), 1'b1);
        repeat (2) tick(8'd0, 1'b0);
        chk("step_env0", env_seq[0], 64);
        chk("step_env1", env_seq[1], 96);
        chk("step_env2", env_seq[2], 128);
        chk("step_env3", env_seq[3], 160);
        chk("step_env4", env_seq[4], 192);
        chk("step_strobes", strobes, 5);

        // 1-in-3 valid: sample j at tick 3j-2; sample 128 at tick 382 -> strobe at 384.
        reset_pulse();
        clear_stats();
        for (int j = 1; j <= 160; j++) begin
            tick(alt(j, 64), 1'b1);
            for (int k = 0; k < 2; k++) begin
                tick(8'd0, 1'b0);
                if (tick_no == 95) chk("gap_busy_boundary", {31'd0, win_busy}, 32'd0);
                if (tick_no == 150) chk("gap_busy_mid", {31'd0, win_busy}, 32'd1);
            end
        end
        chk("gap_first_tick", first_tick, 384);
        chk("gap_spacing", spacing, 96);
        chk("gap_strobes", strobes, 2);
        chk("gap_env", {24'd0, last_env}, 32'd128);

        // Reset right after a window closes: its strobe (due at tick 162) must be killed.
        reset_pulse();
        clear_stats();
        for (int j = 1; j <= 160; j++) tick(alt(j, 64), 1'b1);
        tick(8'd0, 1'b0);
        reset_pulse();
        chk("kill_strobes", strobes, 1);

        // Reset mid-window discards the partial window and the old history.
        clear_stats();
        for (int j = 1; j <= 50; j++) tick(alt(j, 64), 1'b1);
        chk("mid_busy_before", {31'd0, win_busy}, 32'd1);
        reset_pulse();
        clear_stats();
        for (int j = 1; j <= 128; j++) tick(alt(j, 32), 1'b1);
        repeat (2) tick(8'd0, 1'b0);
        chk("post_first_tick", first_tick, 130);
        chk("post_strobes", strobes, 1);
        chk("post_env", {24'd0, last_env}, 32'd64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
